vec_load_seq: RTL and testbench

- Sequencer for vector unit-stride and strided loads; sits between the vector decode/CSR stage and the scalar-side data memory port.
- Takes the decoded load parameters (base in scalar1, stride in scalar2, vl, width, vd, vm) and issues one element request per handshake.
- Packs the returned elements into a VLEN-bit staging buffer, then commits it to the vector register file in a single write.

---
 rtl/vec_de_csr_defs.sv | 37 +++
 rtl/vec_elem_pack.sv | 41 ++++
 rtl/vec_load_seq.sv | 180 ++++++++++++++++++
 tb/tb_vec_load_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_de_csr_defs.sv
// Shared decode/CSR definitions for the vector load path: element-width encodings,
// VLMAX helpers and the load-sequencer state type.
package vec_de_csr_defs;

    localparam int VLEN_DEF = 512;

    localparam logic [2:0] W8  = 3'b000;
    localparam logic [2:0] W16 = 3'b101;
    localparam logic [2:0] W32 = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_FINISH = 3'd4
    } seq_state_t;

    // Returns 0 for an unsupported width encoding.
    function automatic logic [5:0] eew_bits(input logic [2:0] width);
        case (width)
            W8:      return 6'd8;
            W16:     return 6'd16;
            W32:     return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

    // Elements per register at LMUL=1.
    function automatic int unsigned vlmax(input int unsigned vlen, input logic [2:0] width);
        logic [5:0] eew;
        eew = eew_bits(width);
        if (eew == 6'd0) return 0;
        return vlen / 32'(eew);
    endfunction

endpackage

// File: rtl/vec_elem_pack.sv
// Pulls one element out of an aligned memory word and inserts it into the staging
// buffer at element index idx.
module vec_elem_pack
    import vec_de_csr_defs::*;
#(
    parameter int VLEN   = 512,
    parameter int MEM_DW = 32,
    parameter int IW     = 7
) (
    input  logic [VLEN-1:0]   buf_in,
    input  logic [MEM_DW-1:0] word,
    input  logic [1:0]        lane,
    input  logic [IW-1:0]     idx,
    input  logic [2:0]        width,
    output logic [VLEN-1:0]   buf_out
);

    logic [MEM_DW-1:0] elem;

    assign elem = word >> {lane, 3'b000};

    always_comb begin
        buf_out = buf_in;
        case (width)
            W8: begin
                for (int i = 0; i < VLEN / 8; i++)
                    if (i == int'(idx)) buf_out[i*8 +: 8] = elem[7:0];
            end
            W16: begin
                for (int i = 0; i < VLEN / 16; i++)
                    if (i == int'(idx)) buf_out[i*16 +: 16] = elem[15:0];
            end
            W32: begin
                for (int i = 0; i < VLEN / 32; i++)
                    if (i == int'(idx)) buf_out[i*32 +: 32] = elem[31:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_load_seq.sv
// Vector unit-stride / strided load sequencer: one element request per memory
// handshake, packs results into a staging buffer and commits it in one VRF write.
module vec_load_seq
    import vec_de_csr_defs::*;
#(
    parameter int XLEN   = 32,
    parameter int VLEN   = 512,
    parameter int MEM_DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [XLEN-1:0]   base_addr_i,
    input  logic [XLEN-1:0]   stride_i,
    input  logic              strided_i,
    input  logic [2:0]        width_i,
    input  logic [XLEN-1:0]   vl_i,
    input  logic [4:0]        vd_addr_i,
    input  logic              vm_i,
    input  logic [VLEN-1:0]   v0_mask_i,
    input  logic [VLEN-1:0]   vd_old_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [MEM_DW-1:0] mem_rsp_data_i,
    output logic              vrf_we_o,
    output logic [4:0]        vrf_waddr_o,
    output logic [VLEN-1:0]   vrf_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    localparam int IW = $clog2(VLEN / 8) + 1;

    // Request handshake: mem_req_valid_o/mem_addr_o stay stable until the cycle
    // mem_req_ready_i is high; that cycle transfers the request and moves to WAIT.
    seq_state_t        state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     n_q;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   step;
    logic [2:0]        width_q;
    logic              vm_q;
    logic [VLEN-1:0]   v0_q;
    logic [VLEN-1:0]   buf_q;
    logic [4:0]        vd_q;

    logic [5:0]        eew_start;
    logic              width_ok;
    logic [XLEN-1:0]   cap;
    logic [IW-1:0]     n_start;
    logic [XLEN-1:0]   step_start;
    logic [IW-1:0]     idx_nxt;
    logic              last;
    logic              skip;
    logic              misaligned;
    logic [VLEN-1:0]   packed_buf;

    assign eew_start  = eew_bits(width_i);
    assign width_ok   = (eew_start != 6'd0);
    assign cap        = XLEN'(vlmax(VLEN, width_i));
    assign n_start    = (vl_i < cap) ? IW'(vl_i) : IW'(cap);
    assign step_start = strided_i ? stride_i : XLEN'(eew_start >> 3);

    assign idx_nxt    = idx + 1'b1;
    assign last       = (idx_nxt == n_q);
    assign skip       = !vm_q && !v0_q[idx];
    assign misaligned = ((width_q == W16) && addr[0]) ||
                        ((width_q == W32) && (addr[1:0] != 2'b00));

    assign mem_req_valid_o = (state == S_ISSUE) && !skip && !misaligned;
    assign mem_addr_o      = addr;
    assign busy_o          = (state != S_IDLE);
    assign vrf_waddr_o     = vd_q;
    assign vrf_wdata_o     = buf_q;
    assign dbg_state_o     = state;

    vec_elem_pack #(
        .VLEN   (VLEN),
        .MEM_DW (MEM_DW),
        .IW     (IW)
    ) u_pack (
        .buf_in  (buf_q),
        .word    (mem_rsp_data_i),
        .lane    (addr[1:0]),
        .idx     (idx),
        .width   (width_q),
        .buf_out (packed_buf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            n_q      <= '0;
            addr     <= '0;
            step     <= '0;
            width_q  <= '0;
            vm_q     <= 1'b0;
            v0_q     <= '0;
            buf_q    <= '0;
            vd_q     <= '0;
            vrf_we_o <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            vrf_we_o <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        width_q <= width_i;
                        vm_q    <= vm_i;
                        v0_q    <= v0_mask_i;
                        buf_q   <= vd_old_i;
                        vd_q    <= vd_addr_i;
                        step    <= step_start;
                        n_q     <= n_start;
                        idx     <= '0;
                        addr    <= base_addr_i;
                        if (!width_ok) begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else if (n_start == '0) begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (skip) begin
                        idx  <= idx_nxt;
                        addr <= addr + step;
                        if (last) begin
                            state    <= S_COMMIT;
                            vrf_we_o <= 1'b1;
                        end
                    end else if (misaligned) begin
                        state  <= S_FINISH;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else if (mem_req_ready_i) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        buf_q <= packed_buf;
                        idx   <= idx_nxt;
                        addr  <= addr + step;
                        if (last) begin
                            state    <= S_COMMIT;
                            vrf_we_o <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_COMMIT: begin
                    state  <= S_FINISH;
                    done_o <= 1'b1;
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_load_seq.sv
// Bench for vec_load_seq: memory responder, request/commit scoreboard and
// per-scenario tasks.
module tb_vec_load_seq;
    import vec_de_csr_defs::*;

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [31:0]   base_addr_i;
    logic [31:0]   stride_i;
    logic          strided_i;
    logic [2:0]    width_i;
    logic [31:0]   vl_i;
    logic [4:0]    vd_addr_i;
    logic          vm_i;
    logic [511:0]  v0_mask_i;
    logic [511:0]  vd_old_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [31:0]   mem_addr_o;
    logic          mem_rsp_valid_i;
    logic [31:0]   mem_rsp_data_i;
    logic          vrf_we_o;
    logic [4:0]    vrf_waddr_o;
    logic [511:0]  vrf_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [2:0]    dbg_state_o;

    int tests_run = 0;
    int tests_failed = 0;
    int mem_mode = 0;

    logic [31:0]  exp_addr_q[$];
    logic [511:0] exp_wdata_q[$];
    logic [4:0]   exp_waddr_q[$];

    vec_load_seq #(.XLEN(32), .VLEN(512), .MEM_DW(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .stride_i        (stride_i),
        .strided_i       (strided_i),
        .width_i         (width_i),
        .vl_i            (vl_i),
        .vd_addr_i       (vd_addr_i),
        .vm_i            (vm_i),
        .v0_mask_i       (v0_mask_i),
        .vd_old_i        (vd_old_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .vrf_we_o        (vrf_we_o),
        .vrf_waddr_o     (vrf_waddr_o),
        .vrf_wdata_o     (vrf_wdata_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        logic [31:0] w;
        if (mem_mode == 0) return a;
        wa = {a[31:2], 2'b00};
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(wa + 32'(k)) ^ 8'hC3;
        return w;
    endfunction

    // Zero-wait responder: answers in the cycle after the request handshake.
    always begin
        logic        hs;
        logic [31:0] a;
        @(negedge clk);
        hs = mem_req_valid_o && mem_req_ready_i && reset;
        a  = mem_addr_o;
        @(posedge clk);
        #1;
        mem_rsp_valid_i = hs;
        mem_rsp_data_i  = hs ? mem_word(a) : 32'h0;
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                logic [31:0] ea;
                tests_run++;
                if (exp_addr_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL req_addr: unexpected request at 0x%08h, none required", mem_addr_o);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (mem_addr_o !== ea) begin
                        tests_failed++;
                        $display("FAIL req_addr: got 0x%08h required 0x%08h", mem_addr_o, ea);
                    end
                end
            end
            if (vrf_we_o) begin
                logic [511:0] ew;
                logic [4:0]   ev;
                tests_run++;
                if (exp_wdata_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL vrf_write: unexpected VRF write to v%0d, none required", vrf_waddr_o);
                end else begin
                    ew = exp_wdata_q.pop_front();
                    ev = exp_waddr_q.pop_front();
                    if (vrf_wdata_o !== ew || vrf_waddr_o !== ev) begin
                        tests_failed++;
                        $display("FAIL vrf_write: got v%0d 0x%h required v%0d 0x%h",
                                 vrf_waddr_o, vrf_wdata_o, ev, ew);
                    end
                end
            end
        end
    end

    // Reference model: expected request stream and committed register value.
    task automatic expect_seq(input logic [31:0] base, input logic [31:0] stride,
                              input logic strided, input logic [2:0] width, input int vl,
                              input logic vm, input logic [511:0] v0,
                              input logic [511:0] vd_old, input logic [4:0] vd);
        int eew;
        int n;
        logic [31:0]  a;
        logic [31:0]  step;
        logic [31:0]  w;
        logic [511:0] b;
        eew  = (width == 3'b000) ? 8 : (width == 3'b101) ? 16 : 32;
        n    = (vl < 512 / eew) ? vl : 512 / eew;
        step = strided ? stride : 32'(eew / 8);
        b    = vd_old;
        a    = base;
        for (int i = 0; i < n; i++) begin
            if (vm || v0[i]) begin
                exp_addr_q.push_back(a);
                w = mem_word(a) >> (8 * a[1:0]);
                for (int k = 0; k < eew; k++) b[i*eew + k] = w[k];
            end
            a = a + step;
        end
        exp_wdata_q.push_back(b);
        exp_waddr_q.push_back(vd);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_start(input logic [31:0] base, input logic [31:0] stride,
                               input logic strided, input logic [2:0] width, input int vl,
                               input logic [4:0] vd, input logic vm,
                               input logic [511:0] v0, input logic [511:0] vd_old);
        @(posedge clk);
        #1;
        base_addr_i = base;
        stride_i    = stride;
        strided_i   = strided;
        width_i     = width;
        vl_i        = 32'(vl);
        vd_addr_i   = vd;
        vm_i        = vm;
        v0_mask_i   = v0;
        vd_old_i    = vd_old;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
    endtask

    // Cycles (counted at negedges after the start edge) until done_o; -1 on timeout.
    task automatic wait_done(input int budget, output int cyc, output logic got_err);
        cyc = 0;
        got_err = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done_o) begin
                got_err = err_o;
                return;
            end
        end
        cyc = -1;
    endtask

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_done(input string name, input int cyc, input int exp_cyc,
                              input logic got_err, input logic exp_err);
        tests_run++;
        if (cyc !== exp_cyc) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, exp_cyc);
        end
        tests_run++;
        if (got_err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s_err: got %0b required %0b", name, got_err, exp_err);
        end
        tests_run++;
        if (exp_addr_q.size() != 0 || exp_wdata_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d requests and %0d writes still outstanding, required 0 and 0",
                     name, exp_addr_q.size(), exp_wdata_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_req_valid_o, vrf_we_o, busy_o, done_o, err_o} !== 5'b0 ||
            mem_addr_o !== 32'h0 || vrf_waddr_o !== 5'h0 || vrf_wdata_o !== 512'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b we=%0b busy=%0b done=%0b err=%0b addr=0x%08h required all 0",
                     mem_req_valid_o, vrf_we_o, busy_o, done_o, err_o, mem_addr_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy_o !== 1'b0 || dbg_state_o !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%0b state=%0d required busy=0 state=%0d",
                     busy_o, dbg_state_o, S_IDLE);
        end
    endtask

    task automatic test_unit_stride_32();
        logic [511:0] old;
        int cyc;
        logic e;
        mem_mode = 0;
        old = rand_vec();
        expect_seq(32'h100, 32'h0, 1'b0, W32, 4, 1'b1, '0, old, 5'd5);
        drive_start(32'h100, 32'h0, 1'b0, W32, 4, 5'd5, 1'b1, '0, old);
        wait_done(50, cyc, e);
        check_done("unit32", cyc, 10, e, 1'b0);
    endtask

    task automatic test_strided_8();
        logic [511:0] old;
        int cyc;
        logic e;
        mem_mode = 1;
        old = rand_vec();
        expect_seq(32'h203, 32'hFFFF_FFFF, 1'b1, W8, 3, 1'b1, '0, old, 5'd9);
        drive_start(32'h203, 32'hFFFF_FFFF, 1'b1, W8, 3, 5'd9, 1'b1, '0, old);
        wait_done(50, cyc, e);
        check_done("strided8", cyc, 8, e, 1'b0);
    endtask

    task automatic test_masked_16();
        logic [511:0] old;
        logic [511:0] v0;
        int cyc;
        logic e;
        mem_mode = 1;
        old = rand_vec();
        v0 = 512'h5;
        expect_seq(32'h402, 32'h0, 1'b0, W16, 4, 1'b0, v0, old, 5'd17);
        drive_start(32'h402, 32'h0, 1'b0, W16, 4, 5'd17, 1'b0, v0, old);
        wait_done(50, cyc, e);
        check_done("masked16", cyc, 8, e, 1'b0);
    endtask

    task automatic test_vl_zero();
        int cyc;
        logic e;
        drive_start(32'h100, 32'h0, 1'b0, W32, 0, 5'd3, 1'b1, '0, rand_vec());
        wait_done(20, cyc, e);
        check_done("vl_zero", cyc, 1, e, 1'b0);
    endtask

    task automatic test_bad_width();
        int cyc;
        logic e;
        drive_start(32'h100, 32'h0, 1'b0, 3'b011, 4, 5'd3, 1'b1, '0, rand_vec());
        wait_done(20, cyc, e);
        check_done("bad_width", cyc, 1, e, 1'b1);
    endtask

    task automatic test_misaligned();
        int cyc;
        logic e;
        drive_start(32'h102, 32'h0, 1'b0, W32, 4, 5'd3, 1'b1, '0, rand_vec());
        wait_done(20, cyc, e);
        check_done("misaligned", cyc, 2, e, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [511:0] old;
        int cyc;
        logic e;
        mem_mode = 0;
        old = rand_vec();
        mem_req_ready_i = 1'b0;
        expect_seq(32'h800, 32'h0, 1'b0, W32, 2, 1'b1, '0, old, 5'd1);
        drive_start(32'h800, 32'h0, 1'b0, W32, 2, 5'd1, 1'b1, '0, old);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h800) begin
                tests_failed++;
                $display("FAIL backpressure_hold: cycle %0d got valid=%0b addr=0x%08h required valid=1 addr=0x00000800",
                         i, mem_req_valid_o, mem_addr_o);
            end
        end
        @(posedge clk);
        #1;
        mem_req_ready_i = 1'b1;
        wait_done(50, cyc, e);
        check_done("backpressure", (cyc < 0) ? -1 : cyc + 5, 11, e, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [511:0] old;
        int cyc;
        logic e;
        mem_mode = 0;
        exp_addr_q.push_back(32'h100);
        drive_start(32'h100, 32'h0, 1'b0, W32, 4, 5'd7, 1'b1, '0, rand_vec());
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (dbg_state_o !== S_WAIT) begin
            tests_failed++;
            $display("FAIL reset_mid_state: got %0d required %0d", dbg_state_o, S_WAIT);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({mem_req_valid_o, vrf_we_o, busy_o, done_o, err_o} !== 5'b0 ||
            mem_addr_o !== 32'h0 || vrf_waddr_o !== 5'h0 || vrf_wdata_o !== 512'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got valid=%0b we=%0b busy=%0b done=%0b err=%0b addr=0x%08h required all 0",
                     mem_req_valid_o, vrf_we_o, busy_o, done_o, err_o, mem_addr_o);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tests_run++;
        if (exp_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_req: %0d requests outstanding, required 0", exp_addr_q.size());
        end
        old = rand_vec();
        expect_seq(32'h300, 32'h0, 1'b0, W32, 4, 1'b1, '0, old, 5'd12);
        drive_start(32'h300, 32'h0, 1'b0, W32, 4, 5'd12, 1'b1, '0, old);
        wait_done(50, cyc, e);
        check_done("after_reset", cyc, 10, e, 1'b0);
    endtask

    initial begin
        reset           = 1'b0;
        start_i         = 1'b0;
        base_addr_i     = '0;
        stride_i        = '0;
        strided_i       = 1'b0;
        width_i         = '0;
        vl_i            = '0;
        vd_addr_i       = '0;
        vm_i            = 1'b1;
        v0_mask_i       = '0;
        vd_old_i        = '0;
        mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;

        test_reset();
        test_unit_stride_32();
        test_strided_8();
        test_masked_16();
        test_vl_zero();
        test_bad_width();
        test_misaligned();
        test_backpressure();
        test_reset_mid();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
